// File: rtl/gcd_cpu_core_if.sv
// Memory bus between gcd_cpu_core (master) and its synchronous program/data RAM (slave).
interface gcd_cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/gcd_cpu_core.sv
// Two-register (A,B) multi-cycle accumulator core fetching 16-opcode programs from a
// synchronous RAM, with start/halt handshake, zero and carry/borrow flags and a retire strobe.
module gcd_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  gcd_cpu_core_if.master    mem,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              flag_z,
  output logic              flag_c
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_MEMRD, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_AEQB = 4'd0,  OP_BEQA = 4'd1,  OP_ADD  = 4'd2,  OP_ADDB = 4'd3,
    OP_SUB  = 4'd4,  OP_SUBB = 4'd5,  OP_LDA  = 4'd6,  OP_LDB  = 4'd7,
    OP_STA  = 4'd8,  OP_LDM  = 4'd9,  OP_CMP  = 4'd10, OP_JMP  = 4'd11,
    OP_JZ   = 4'd12, OP_JC   = 4'd13, OP_NOP  = 4'd14, OP_HLT  = 4'd15
  } opcode_t;

  state_t            state, state_n;
  opcode_t           ir, ir_n, op_dec;
  logic [ADDR_W-1:0] pc, pc_n, pc1, pc2, op_addr;
  logic [DATA_W-1:0] a_n, b_n;
  logic              z_n, c_n;
  logic [DATA_W:0]   sum, diff_ab, diff_ba;

  assign op_dec  = opcode_t'(mem.mem_rdata[3:0]);
  assign op_addr = mem.mem_rdata[ADDR_W-1:0];
  assign pc1     = pc + ADDR_W'(1);
  assign pc2     = pc + ADDR_W'(2);
  // The extra top bit of each difference is the borrow (subtrahend > minuend).
  assign sum     = {1'b0, reg_a} + {1'b0, reg_b};
  assign diff_ab = {1'b0, reg_a} - {1'b0, reg_b};
  assign diff_ba = {1'b0, reg_b} - {1'b0, reg_a};

  assign mem.mem_wdata = reg_a;
  assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_OPERAND) || (state == S_MEMRD);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= OP_NOP;
      pc     <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state  <= state_n;
      ir     <= ir_n;
      pc     <= pc_n;
      reg_a  <= a_n;
      reg_b  <= b_n;
      flag_z <= z_n;
      flag_c <= c_n;
    end
  end

  always_comb begin
    state_n      = state;
    ir_n         = ir;
    pc_n         = pc;
    a_n          = reg_a;
    b_n          = reg_b;
    z_n          = flag_z;
    c_n          = flag_c;
    mem.mem_addr = pc;
    mem.mem_we   = 1'b0;
    retire       = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
          a_n     = '0;
          b_n     = '0;
          z_n     = 1'b0;
          c_n     = 1'b0;
        end
      end

      S_FETCH: state_n = S_DECODE;

      S_DECODE: begin
        mem.mem_addr = pc1;
        ir_n         = op_dec;
        // Single-cycle ops finish here; everything else defaults to the operand fetch.
        state_n      = S_FETCH;
        pc_n         = pc1;
        retire       = 1'b1;
        case (op_dec)
          OP_AEQB: a_n = reg_b;
          OP_BEQA: b_n = reg_a;
          OP_ADD: begin
            a_n = sum[DATA_W-1:0];
            z_n = (sum[DATA_W-1:0] == '0);
            c_n = sum[DATA_W];
          end
          OP_ADDB: begin
            b_n = sum[DATA_W-1:0];
            z_n = (sum[DATA_W-1:0] == '0);
            c_n = sum[DATA_W];
          end
          OP_SUB: begin
            a_n = diff_ab[DATA_W-1:0];
            z_n = (diff_ab[DATA_W-1:0] == '0);
            c_n = diff_ab[DATA_W];
          end
          OP_SUBB: begin
            b_n = diff_ba[DATA_W-1:0];
            z_n = (diff_ba[DATA_W-1:0] == '0);
            c_n = diff_ba[DATA_W];
          end
          OP_CMP: begin
            z_n = (reg_a == reg_b);
            c_n = diff_ab[DATA_W];
          end
          OP_NOP: ;
          OP_HLT: begin
            state_n = S_HALT;
            pc_n    = pc;
          end
          OP_JZ, OP_JC: begin
            if ((op_dec == OP_JZ) ? flag_z : flag_c) begin
              state_n = S_OPERAND;
              pc_n    = pc;
              retire  = 1'b0;
            end else begin
              pc_n = pc2;
            end
          end
          default: begin
            state_n = S_OPERAND;
            pc_n    = pc;
            retire  = 1'b0;
          end
        endcase
      end

      S_OPERAND: begin
        state_n = S_FETCH;
        pc_n    = pc2;
        retire  = 1'b1;
        case (ir)
          OP_LDA: a_n = mem.mem_rdata;
          OP_LDB: b_n = mem.mem_rdata;
          OP_STA: begin
            mem.mem_addr = op_addr;
            mem.mem_we   = 1'b1;
          end
          OP_LDM: begin
            mem.mem_addr = op_addr;
            state_n      = S_MEMRD;
            pc_n         = pc;
            retire       = 1'b0;
          end
          OP_JMP, OP_JZ, OP_JC: pc_n = op_addr;
          default: ;
        endcase
      end

      S_MEMRD: begin
        a_n     = mem.mem_rdata;
        pc_n    = pc2;
        retire  = 1'b1;
        state_n = S_FETCH;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
